// File: rtl/decode_scoreboard_ctrl.sv
// Decode-stage register scoreboard: tracks in-flight writes per register,
// stalls decode on RAW hazards or counter saturation, and counts stall cycles.
module decode_scoreboard_ctrl #(
  parameter int NREGS = 16,
  parameter int RADDR = 4,
  parameter int CNTW  = 2,
  parameter int STATW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [RADDR-1:0] dec_rs1,
  input  logic [RADDR-1:0] dec_rs2,
  input  logic [RADDR-1:0] dec_rd,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             dec_wr_rd,
  input  logic             kill,
  input  logic             wb_valid,
  input  logic [RADDR-1:0] wb_rd,
  input  logic             clr_stats,
  output logic             stall,
  output logic             issue,
  output logic [NREGS-1:0] busy_mask,
  output logic [STATW-1:0] stall_count,
  output logic             err
);

  localparam logic [CNTW-1:0]  CNT_MAX  = '1;
  localparam logic [STATW-1:0] STAT_MAX = '1;

  logic [CNTW-1:0]  cnt_q [NREGS];
  logic [CNTW-1:0]  cnt_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [STATW-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  logic raw1, raw2, wfull, live, underflow;

  // Hazard detection: r0 is never tracked, so index 0 can never hazard.
  assign raw1  = dec_use_rs1 && (dec_rs1 != '0) && (cnt_q[dec_rs1] != '0);
  assign raw2  = dec_use_rs2 && (dec_rs2 != '0) && (cnt_q[dec_rs2] != '0);
  assign wfull = dec_wr_rd   && (dec_rd  != '0) && (cnt_q[dec_rd]  == CNT_MAX);

  assign live  = dec_valid && !kill;
  assign stall = live && (raw1 || raw2 || wfull);
  assign issue = live && !stall;

  assign underflow = wb_valid && (wb_rd != '0) && (cnt_q[wb_rd] == '0);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d[0] = '0;
    busy_d   = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      logic inc, dec;
      inc      = issue && dec_wr_rd && (dec_rd == RADDR'(r));
      dec      = wb_valid && (wb_rd == RADDR'(r)) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != STAT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    err_d = err_q || underflow;
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
  // like any other state; a stale count after reset would deadlock decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q      <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample
      // the same pre-edge values.
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign busy_mask   = busy_q;
  assign stall_count = stall_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_decode_scoreboard_ctrl.sv
// Directed self-checking bench for decode_scoreboard_ctrl; inputs change just
// after the falling edge and outputs are sampled 1ns later.
module tb_decode_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_rd, kill;
  logic [3:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        wb_valid, clr_stats;
  logic        stall, issue, err;
  logic [15:0] busy_mask, stall_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decode_scoreboard_ctrl dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .kill(kill), .wb_valid(wb_valid), .wb_rd(wb_rd), .clr_stats(clr_stats),
    .stall(stall), .issue(issue), .busy_mask(busy_mask),
    .stall_count(stall_count), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr_rd = 0; kill = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; wb_valid = 0; wb_rd = 0; clr_stats = 0;
  endtask

  // Advance to the next falling edge and start from quiet inputs.
  task automatic next();
    @(negedge clk);
    clear_in();
  endtask

  task automatic wr(input logic [3:0] rd);
    dec_valid = 1; dec_wr_rd = 1; dec_rd = rd;
  endtask

  task automatic rd1(input logic [3:0] rs);
    dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = rs;
  endtask

  task automatic wb(input logic [3:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  initial begin
    clear_in();
    rst = 0;
    #12;
    check("rst_busy", busy_mask, 0);
    check("rst_cnt", stall_count, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);
    @(negedge clk); rst = 1;

    // 1: write r3 issues, then r3 busy
    next(); wr(3); #1;
    check("t1_issue", issue, 1);
    check("t1_stall", stall, 0);

    // 2: RAW on r3 for three cycles, then a writeback cycle that still stalls
    next(); rd1(3); #1;
    check("t2_busy", busy_mask, 16'h0008);
    check("t2_stall_a", stall, 1);
    next(); rd1(3); #1;
    check("t2_stall_b", stall, 1);
    next(); rd1(3); #1;
    check("t2_stall_c", stall, 1);
    check("t2_cnt_c", stall_count, 2);
    next(); rd1(3); wb(3); #1;
    check("t2_stall_wb", stall, 1);
    check("t2_issue_wb", issue, 0);
    next(); rd1(3); #1;
    check("t2_issue", issue, 1);
    check("t2_busy0", busy_mask, 0);
    check("t2_cnt", stall_count, 4);

    // 3: r0 writes and reads are never tracked
    next(); wr(0); #1;
    check("t3_issue_w0", issue, 1);
    next(); rd1(0); #1;
    check("t3_stall_r0", stall, 0);
    check("t3_issue_r0", issue, 1);
    check("t3_busy", busy_mask, 0);
    next(); wb(0); #1;
    next(); #1;
    check("t3_err", err, 0);
    check("t3_cnt", stall_count, 4);

    // 4: saturate r5, stalled write plus same-cycle wb
    for (int i = 0; i < 3; i++) begin
      next(); wr(5); #1;
      check("t4_issue_fill", issue, 1);
    end
    next(); wr(5); #1;
    check("t4_busy", busy_mask, 16'h0020);
    check("t4_wfull", stall, 1);
    next(); wr(5); wb(5); #1;
    check("t4_wfull_wb", stall, 1);
    next(); wr(5); #1;
    check("t4_issue_after", issue, 1);
    next(); wr(5); #1;
    check("t4_full_again", stall, 1);
    check("t4_cnt", stall_count, 6);

    // 5: kill masks hazards and counter updates
    next(); wr(5); kill = 1; #1;
    check("t5_kill_stall", stall, 0);
    check("t5_kill_issue", issue, 0);
    next(); #1;
    check("t5_kill_cnt", stall_count, 7);
    // drain r5: three writebacks needed, so count was exactly 3
    next(); wb(5); #1;
    next(); wb(5); #1;
    check("t4_drain2", busy_mask, 16'h0020);
    next(); wb(5); #1;
    check("t4_drain2b", busy_mask, 16'h0020);
    next(); #1;
    check("t4_drain3", busy_mask, 0);
    check("t4_drain_err", err, 0);

    next(); wr(9); #1;
    next(); rd1(9); kill = 1; #1;
    check("t5_raw_kill_stall", stall, 0);
    check("t5_raw_kill_issue", issue, 0);
    next(); wr(10); kill = 1; #1;
    next(); #1;
    check("t5_busy", busy_mask, 16'h0200);
    check("t5_cnt", stall_count, 7);
    // simultaneous issue and writeback on r9 leaves count at 1
    next(); wr(9); wb(9); #1;
    check("t5_incdec_issue", issue, 1);
    next(); #1;
    check("t5_incdec_busy", busy_mask, 16'h0200);
    next(); wb(9); #1;
    next(); #1;
    check("t5_drain", busy_mask, 0);

    // 6: writeback underflow is sticky
    next(); wb(7); #1;
    next(); #1;
    check("t6_err", err, 1);
    check("t6_busy", busy_mask, 0);
    next(); #1;
    check("t6_sticky", err, 1);

    // clr_stats, then build stall_count = 9
    next(); clr_stats = 1; #1;
    next(); #1;
    check("clr_cnt", stall_count, 0);
    next(); wr(2); #1;
    for (int i = 0; i < 9; i++) begin
      next(); rd1(2); #1;
    end
    next(); rd1(2); #1;
    check("t7_pre_cnt", stall_count, 9);
    check("t7_pre_stall", stall, 1);

    // 7: asynchronous reset mid-stall
    rst = 0; #1;
    check("t7_busy", busy_mask, 0);
    check("t7_cnt", stall_count, 0);
    check("t7_err", err, 0);
    check("t7_stall", stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard_ctrl.md
Name: decode_scoreboard_ctrl

Overview:
Register scoreboard and stall controller for the 16-bit pipeline's decode stage. It tracks in-flight register writes between issue from decode and completion at writeback. It holds decode (stall) on RAW hazards and on write-counter saturation. It also keeps a saturating stall-cycle counter for performance visibility.

Parameters:
NREGS, 16, number of architectural registers; r0 is hardwired zero and never tracked.
RADDR, 4, register index width.
CNTW, 2, width of the per-register in-flight write counter; maximum count is 2^CNTW-1 (3).
STATW, 16, stall counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
dec_valid  in  1  decode holds a valid instruction this cycle.
dec_rs1  in  RADDR  source register 1 index.
dec_rs2  in  RADDR  source register 2 index.
dec_rd  in  RADDR  destination register index.
dec_use_rs1  in  1  instruction reads rs1.
dec_use_rs2  in  1  instruction reads rs2.
dec_wr_rd  in  1  instruction writes rd.
kill  in  1  squash the decode instruction (branch redirect).
wb_valid  in  1  writeback completes a register write this cycle.
wb_rd  in  RADDR  writeback destination index.
clr_stats  in  1  synchronous clear of stall_count.
stall  out  1  combinational; hold IR/PC in decode.
issue  out  1  combinational; decode instruction advances this cycle.
busy_mask  out  NREGS  registered; bit i = (cnt[i] != 0); bit 0 always 0.
stall_count  out  STATW  registered, saturating count of stall cycles.
err  out  1  registered, sticky writeback-underflow flag.

Behaviour:
- Reset (rst=0, asynchronous): every cnt[i]=0, busy_mask=0, stall_count=0, err=0. These take effect immediately, including mid-stall. After reset, stall=0 until a hazard exists.
- raw1 = dec_use_rs1 & (dec_rs1!=0) & (cnt[dec_rs1]!=0). raw2 is defined the same way for rs2.
- wfull = dec_wr_rd & (dec_rd!=0) & (cnt[dec_rd]==max).
- stall = dec_valid & ~kill & (raw1 | raw2 | wfull).
- issue = dec_valid & ~kill & ~stall.
- There is no writeback bypass. A register at cnt=1 whose writeback occurs this cycle still stalls its reader. The reader issues the following cycle.
- WAW is permitted while the counter is below max. Reads wait until all pending writes retire (cnt=0).
- Counter update per clock edge, for register r != 0:
  - inc = issue & dec_wr_rd & (dec_rd==r).
  - dec = wb_valid & (wb_rd==r) & (cnt[r]!=0).
  - inc&dec leaves cnt[r] unchanged. inc alone adds 1. dec alone subtracts 1.
- Writes to r0, both issue and writeback, never change state and never set err.
- Underflow: wb_valid with wb_rd!=0 and cnt[wb_rd]==0 leaves the count at 0 and sets err=1. err stays set until reset.
- busy_mask is updated at the same edge as the counters and reflects post-update counts.
- stall_count update per edge:
  - clr_stats=1 loads 0; this has priority.
  - Otherwise, stall=1 increments the count, saturating at all-ones.
  - Killed cycles and idle cycles do not count.
- kill has priority over hazard detection. A killed instruction produces no issue, no counter change and no stall count.
- Single writeback port: at most one decrement per cycle.
- All state is updated only on the rising clk edge, except for asynchronous reset.

Test Plan:
1. Reset, then dec_valid=1, dec_wr_rd=1, dec_rd=3 -> issue=1, stall=0 that cycle; next cycle busy_mask=16'h0008.
2. Next, dec_use_rs1=1, dec_rs1=3 held -> stall=1 for 3 cycles. Then wb_valid=1, wb_rd=3 -> stall still 1 in the wb cycle; the following cycle gives issue=1, busy_mask=0, stall_count=4.
3. dec_rd=0 write issued, then dec_rs1=0 read -> busy_mask stays 0, stall never asserts, err=0.
4. Three issued writes to r5 -> cnt[5]=3. A fourth write to r5 gives stall=1. Same-cycle wb r5 plus a stalled write: the write issues the next cycle, and cnt ends at 3.
5. RAW hazard present with kill=1 -> stall=0, issue=0, busy_mask unchanged, stall_count unchanged.
6. wb_valid=1, wb_rd=7 with cnt[7]=0 -> err=1 (sticky), busy_mask bit 7 stays 0.
7. Assert rst low mid-stall with stall_count=9 -> all outputs clear immediately, without waiting for a clock edge.
